// File: rtl/network_descriptor_arbiter_if.sv
// Descriptor handshake bundle between the two requesters (host, network),
// the arbiter, and the transmit-side consumer.
interface network_descriptor_arbiter_if;
  logic [47:0] iv_tsntag_host;
  logic [8:0]  iv_bufid_host;
  logic        i_descriptor_wr_host;
  logic        o_descriptor_ack_host;
  logic [47:0] iv_tsntag_network;
  logic [8:0]  iv_bufid_network;
  logic        i_descriptor_wr_network;
  logic        o_descriptor_ack_network;
  logic [56:0] ov_descriptor;
  logic        o_descriptor_wr;
  logic        i_descriptor_ready;

  modport master (
    input  iv_tsntag_host, iv_bufid_host, i_descriptor_wr_host,
    output o_descriptor_ack_host,
    input  iv_tsntag_network, iv_bufid_network, i_descriptor_wr_network,
    output o_descriptor_ack_network,
    output ov_descriptor, o_descriptor_wr,
    input  i_descriptor_ready
  );

  modport slave (
    output iv_tsntag_host, iv_bufid_host, i_descriptor_wr_host,
    input  o_descriptor_ack_host,
    output iv_tsntag_network, iv_bufid_network, i_descriptor_wr_network,
    input  o_descriptor_ack_network,
    input  ov_descriptor, o_descriptor_wr,
    output i_descriptor_ready
  );
endinterface

// File: rtl/network_descriptor_arbiter.sv
// Weighted round-robin arbiter feeding one descriptor at a time from the host
// or network requester into the transmit path, with per-source grant counters.
module network_descriptor_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            iv_cfg_finish,
  input  logic [3:0]            iv_host_weight,
  input  logic [3:0]            iv_network_weight,
  network_descriptor_arbiter_if.master bus,
  output logic [CNT_W-1:0]      ov_host_grant_cnt,
  output logic [CNT_W-1:0]      ov_network_grant_cnt,
  output logic [1:0]            arb_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1
  } state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;     // 0: host, 1: network
  logic [3:0]        credit, credit_nxt;
  logic [3:0]        lim;
  logic              grant_host, grant_net;
  logic              ack_host_p0, ack_net_p0;
  logic [56:0]       desc_p0;
  logic              vld_p0;
  logic [CNT_W-1:0]  host_cnt, net_cnt;

  function automatic logic [3:0] eff_weight(input logic [3:0] w);
    return (w == 4'd0) ? 4'd1 : w;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      credit <= 4'd0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      credit <= credit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    credit_nxt = credit;
    grant_host = 1'b0;
    grant_net  = 1'b0;
    lim        = (owner ? eff_weight(iv_network_weight) : eff_weight(iv_host_weight)) - 4'd1;
    case (state)
      IDLE: begin
        if (iv_cfg_finish == 2'b11 &&
            (bus.i_descriptor_wr_host || bus.i_descriptor_wr_network)) begin
          state_nxt = OUT;
          if (bus.i_descriptor_wr_host && bus.i_descriptor_wr_network) begin
            // Credit above a freshly reduced weight also lands here and switches.
            if (credit < lim) begin
              grant_host = ~owner;
              grant_net  = owner;
              credit_nxt = credit + 4'd1;
            end else begin
              grant_host = owner;
              grant_net  = ~owner;
              owner_nxt  = ~owner;
              credit_nxt = 4'd0;
            end
          end else begin
            grant_host = bus.i_descriptor_wr_host;
            grant_net  = bus.i_descriptor_wr_network;
            if (bus.i_descriptor_wr_network == owner) begin
              credit_nxt = (credit < lim) ? credit + 4'd1 : lim;
            end else begin
              owner_nxt  = bus.i_descriptor_wr_network;
              credit_nxt = 4'd0;
            end
          end
        end
      end
      OUT: begin
        if (bus.i_descriptor_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output stage: grant decision registered into ack pulse, descriptor and valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_host_p0 <= 1'b0;
      ack_net_p0  <= 1'b0;
      desc_p0     <= '0;
      vld_p0      <= 1'b0;
      host_cnt    <= '0;
      net_cnt     <= '0;
    end else begin
      ack_host_p0 <= grant_host;
      ack_net_p0  <= grant_net;
      if (grant_host || grant_net) begin
        desc_p0 <= grant_host ? {bus.iv_tsntag_host, bus.iv_bufid_host}
                              : {bus.iv_tsntag_network, bus.iv_bufid_network};
        vld_p0  <= 1'b1;
      end else if (state == OUT && bus.i_descriptor_ready) begin
        vld_p0  <= 1'b0;
      end
      if (grant_host) host_cnt <= host_cnt + CNT_W'(1);
      if (grant_net)  net_cnt  <= net_cnt + CNT_W'(1);
    end
  end

  assign bus.o_descriptor_ack_host    = ack_host_p0;
  assign bus.o_descriptor_ack_network = ack_net_p0;
  assign bus.ov_descriptor            = desc_p0;
  assign bus.o_descriptor_wr          = vld_p0;
  assign ov_host_grant_cnt            = host_cnt;
  assign ov_network_grant_cnt         = net_cnt;
  assign arb_state                    = state;

endmodule

// File: tb/tb_network_descriptor_arbiter.sv
// Scoreboard bench for network_descriptor_arbiter: directed request patterns,
// expected grant order written by hand, monitor checks every ack pulse.
module tb_network_descriptor_arbiter;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       cfg;
  logic [3:0]       wh, wn;
  logic [CNT_W-1:0] hcnt, ncnt;
  logic [1:0]       st;

  always #5 clk = ~clk;

  network_descriptor_arbiter_if bus();

  network_descriptor_arbiter #(.CNT_W(CNT_W)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .iv_cfg_finish        (cfg),
    .iv_host_weight       (wh),
    .iv_network_weight    (wn),
    .bus                  (bus.master),
    .ov_host_grant_cnt    (hcnt),
    .ov_network_grant_cnt (ncnt),
    .arb_state            (st)
  );

  int errors = 0;
  int checks = 0;
  int host_total = 0, net_total = 0;
  int host_idx = 0, net_idx = 0;
  int exp_h = 0, exp_n = 0;
  int cyc = 0;
  logic [57:0] expq[$];
  int ack_cyc[$];

  function automatic logic [56:0] hdesc(input int k);
    return {48'hA5A5_0000_0000 + 48'(k), 9'(32'h040 + k)};
  endfunction

  function automatic logic [56:0] ndesc(input int k);
    return {48'h5A5A_0000_1000 + 48'(k), 9'(32'h180 + k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) == 8'h48) begin
        expq.push_back({1'b0, hdesc(exp_h)});
        exp_h++;
      end else begin
        expq.push_back({1'b1, ndesc(exp_n)});
        exp_n++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", name}, 64'(expq.size()), 64'd0);
    expq.delete();
    repeat (3) @(negedge clk);
  endtask

  // Requesters: hold wr with stable data, advance to the next item once ack is seen
  initial begin
    logic [56:0] d;
    bus.i_descriptor_wr_host    = 1'b0;
    bus.i_descriptor_wr_network = 1'b0;
    bus.iv_tsntag_host = '0; bus.iv_bufid_host = '0;
    bus.iv_tsntag_network = '0; bus.iv_bufid_network = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.o_descriptor_ack_host)    host_idx++;
      if (bus.o_descriptor_ack_network) net_idx++;
      d = hdesc(host_idx);
      {bus.iv_tsntag_host, bus.iv_bufid_host} = d;
      bus.i_descriptor_wr_host = (host_idx < host_total);
      d = ndesc(net_idx);
      {bus.iv_tsntag_network, bus.iv_bufid_network} = d;
      bus.i_descriptor_wr_network = (net_idx < net_total);
    end
  end

  // Monitor: every ack pulse must match the head of the expected queue
  initial begin
    logic [57:0] e;
    logic        prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_descriptor_ack_host || bus.o_descriptor_ack_network) begin
        chk("ack_overlap", 64'(bus.o_descriptor_ack_host & bus.o_descriptor_ack_network), 64'd0);
        chk("ack_width", 64'(prev_ack), 64'd0);
        ack_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: host=%0b net=%0b desc=%0h with none expected",
                   bus.o_descriptor_ack_host, bus.o_descriptor_ack_network, bus.ov_descriptor);
        end else begin
          e = expq.pop_front();
          chk("grant_src", 64'(bus.o_descriptor_ack_network), 64'(e[57]));
          chk("grant_desc", 64'(bus.ov_descriptor), 64'(e[56:0]));
          chk("grant_wr", 64'(bus.o_descriptor_wr), 64'd1);
        end
      end
      prev_ack = bus.o_descriptor_ack_host | bus.o_descriptor_ack_network;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    cfg = 2'b11; wh = 4'd3; wn = 4'd1;
    bus.i_descriptor_ready = 1'b0;
    host_total = 1; net_total = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acks", 64'({bus.o_descriptor_ack_host, bus.o_descriptor_ack_network}), 64'd0);
    chk("rst_desc", 64'(bus.ov_descriptor), 64'd0);
    chk("rst_wr", 64'(bus.o_descriptor_wr), 64'd0);
    chk("rst_cnts", {32'(hcnt), 32'(ncnt)}, 64'd0);
    chk("rst_state", 64'(st), 64'd0);

    // First grant after reset goes to host; then hold OUT with ready low
    push("H");
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_ack_host", 64'(bus.o_descriptor_ack_host), 64'd1);
    @(negedge clk);
    chk("ack_one_cycle", 64'(bus.o_descriptor_ack_host), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out", {bus.o_descriptor_wr, bus.ov_descriptor, bus.o_descriptor_ack_host,
                       bus.o_descriptor_ack_network, st},
          {1'b1, hdesc(0), 1'b0, 1'b0, 2'd1});
    end
    push("N");
    bus.i_descriptor_ready = 1'b1;
    @(negedge clk);
    bus.i_descriptor_ready = 1'b0;
    chk("wr_drop", 64'({bus.o_descriptor_wr, st}), 64'd0);
    @(negedge clk);
    chk("next_grant_net", 64'(bus.o_descriptor_ack_network), 64'd1);
    bus.i_descriptor_ready = 1'b1;
    wait_drain("t1");

    // Weights 3/1, both requesting, owner currently network
    ack_cyc.delete();
    push("HHHNHHHN");
    host_total += 6; net_total += 2;
    wait_drain("wrr31");
    chk("wrr_grants", 64'(ack_cyc.size()), 64'd8);
    for (int i = 1; i < ack_cyc.size(); i++)
      chk("wrr_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd2);
    chk("host_cnt", 64'(hcnt), 64'd7);
    chk("net_cnt", 64'(ncnt), 64'd3);

    // Zero weights act as 1: strict alternation
    wh = 4'd0; wn = 4'd0;
    push("HNHN");
    host_total += 2; net_total += 2;
    wait_drain("w00");

    // Arbitration disabled: request waits
    cfg = 2'b01;
    net_total += 1;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_descriptor_ack_network || bus.o_descriptor_ack_host) acks++;
    end
    chk("cfg_off_no_ack", 64'(acks), 64'd0);
    push("N");
    cfg = 2'b11;
    @(negedge clk);
    chk("cfg_on_ack_net", 64'(bus.o_descriptor_ack_network), 64'd1);
    wait_drain("cfg");

    // Reset while in OUT, host keeps requesting across reset
    bus.i_descriptor_ready = 1'b0;
    push("H");
    host_total += 2;
    wait_drain("pre_rst");
    chk("out_before_rst", 64'({bus.o_descriptor_wr, st}), {61'd0, 1'b1, 2'd1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {bus.o_descriptor_ack_host, bus.o_descriptor_ack_network,
                           bus.o_descriptor_wr, st, 2'b00, bus.ov_descriptor}, 64'd0);
    chk("async_rst_cnts", {32'(hcnt), 32'(ncnt)}, 64'd0);
    push("H");
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_descriptor_ready = 1'b1;
    wait_drain("post_rst");
    chk("post_rst_host_cnt", 64'(hcnt), 64'd1);
    chk("post_rst_net_cnt", 64'(ncnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
